// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Arbitrates two requesters (memory stage "m", loader "l") onto a single-port
// 1024 x 64 synchronous memory. One transaction in flight:
//   IDLE -> ACCESS (gnt + memory strobe) -> RESP (rvalid + rdata) -> IDLE.
// Fixed latency: request sampled on edge N, gnt in cycle N+1, rvalid in N+2.
//
// Configuration macro:
//   DMEM_RR_EN  defined   -> round-robin between simultaneous requests
//               undefined -> fixed priority, m always wins
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   m_req/m_we/m_addr/m_wdata       memory-stage request
//   m_gnt/m_rvalid/m_rdata          memory-stage grant / response
//   l_req/l_we/l_addr/l_wdata       loader request
//   l_gnt/l_rvalid/l_rdata          loader grant / response
//   mem_en/mem_we/mem_addr/mem_wdata  memory strobe and write payload
//   mem_rdata                       memory read data (valid cycle after mem_en)
//   busy                            FSM not in IDLE
//   addr_err                        pulse with rvalid for out-of-range access
// -----------------------------------------------------------------------------
module dmem_arbiter (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        m_req,
    input  logic        m_we,
    input  logic [63:0] m_addr,
    input  logic [63:0] m_wdata,
    output logic        m_gnt,
    output logic        m_rvalid,
    output logic [63:0] m_rdata,

    input  logic        l_req,
    input  logic        l_we,
    input  logic [63:0] l_addr,
    input  logic [63:0] l_wdata,
    output logic        l_gnt,
    output logic        l_rvalid,
    output logic [63:0] l_rdata,

    output logic        mem_en,
    output logic        mem_we,
    output logic [9:0]  mem_addr,
    output logic [63:0] mem_wdata,
    input  logic [63:0] mem_rdata,

    output logic        busy,
    output logic        addr_err
);

    localparam int unsigned DATA_W = 64;
    localparam int unsigned ADDR_W = 64;
    localparam int unsigned MEM_AW = 10;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    // State and latched transaction attributes
    logic [1:0]        r_state;
    logic              r_win_l;
    logic              r_we;
    logic              r_oor;

    // Registered outputs
    logic              r_m_gnt;
    logic              r_l_gnt;
    logic              r_m_rvalid;
    logic              r_l_rvalid;
    logic              r_mem_en;
    logic              r_mem_we;
    logic [MEM_AW-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_busy;
    logic              r_addr_err;
    logic [DATA_W-1:0] r_m_hold;
    logic [DATA_W-1:0] r_l_hold;

    // Next-state / next-output values
    logic [1:0]        w_state_nxt;
    logic              w_win_l_nxt;
    logic              w_we_nxt;
    logic              w_oor_nxt;
    logic              w_m_gnt_nxt;
    logic              w_l_gnt_nxt;
    logic              w_m_rvalid_nxt;
    logic              w_l_rvalid_nxt;
    logic              w_mem_en_nxt;
    logic              w_mem_we_nxt;
    logic [MEM_AW-1:0] w_mem_addr_nxt;
    logic [DATA_W-1:0] w_mem_wdata_nxt;
    logic              w_busy_nxt;
    logic              w_addr_err_nxt;
    logic [DATA_W-1:0] w_m_hold_nxt;
    logic [DATA_W-1:0] w_l_hold_nxt;

    // Winner selection and selected payload
    logic              w_sel_l;
    logic              w_sel_we;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_wdata;
    logic              w_sel_oor;
    logic [DATA_W-1:0] w_resp_data;

`ifdef DMEM_RR_EN
    // Set when the loader should win the next simultaneous request
    logic r_prio_l;
    logic w_prio_l_nxt;

    assign w_sel_l = l_req & (~m_req | r_prio_l);
`else
    assign w_sel_l = l_req & ~m_req;
`endif

    assign w_sel_we    = w_sel_l ? l_we    : m_we;
    assign w_sel_addr  = w_sel_l ? l_addr  : m_addr;
    assign w_sel_wdata = w_sel_l ? l_wdata : m_wdata;
    assign w_sel_oor   = |w_sel_addr[ADDR_W-1:MEM_AW];

    // Writes and out-of-range accesses return zero data
    assign w_resp_data = (r_we | r_oor) ? '0 : mem_rdata;

    // Next-state and next-output logic
    always_comb begin
        w_state_nxt     = r_state;
        w_win_l_nxt     = r_win_l;
        w_we_nxt        = r_we;
        w_oor_nxt       = r_oor;
        w_m_gnt_nxt     = 1'b0;
        w_l_gnt_nxt     = 1'b0;
        w_m_rvalid_nxt  = 1'b0;
        w_l_rvalid_nxt  = 1'b0;
        w_mem_en_nxt    = 1'b0;
        w_mem_we_nxt    = 1'b0;
        w_mem_addr_nxt  = '0;
        w_mem_wdata_nxt = '0;
        w_busy_nxt      = 1'b0;
        w_addr_err_nxt  = 1'b0;
        w_m_hold_nxt    = r_m_hold;
        w_l_hold_nxt    = r_l_hold;
`ifdef DMEM_RR_EN
        w_prio_l_nxt    = r_prio_l;
`endif

        case (r_state)
            ST_IDLE: begin
                if (m_req | l_req) begin
                    w_state_nxt     = ST_ACCESS;
                    w_win_l_nxt     = w_sel_l;
                    w_we_nxt        = w_sel_we;
                    w_oor_nxt       = w_sel_oor;
                    w_m_gnt_nxt     = ~w_sel_l;
                    w_l_gnt_nxt     = w_sel_l;
                    // Out-of-range: grant still issued, memory never strobed
                    w_mem_en_nxt    = ~w_sel_oor;
                    w_mem_we_nxt    = w_sel_we & ~w_sel_oor;
                    w_mem_addr_nxt  = w_sel_addr[MEM_AW-1:0];
                    w_mem_wdata_nxt = w_sel_wdata;
                    w_busy_nxt      = 1'b1;
`ifdef DMEM_RR_EN
                    w_prio_l_nxt    = ~w_sel_l;
`endif
                end
            end
            ST_ACCESS: begin
                w_state_nxt    = ST_RESP;
                w_m_rvalid_nxt = ~r_win_l;
                w_l_rvalid_nxt = r_win_l;
                w_addr_err_nxt = r_oor;
                w_busy_nxt     = 1'b1;
            end
            ST_RESP: begin
                w_state_nxt = ST_IDLE;
                // Capture the response so rdata holds until the next rvalid
                if (r_win_l) begin
                    w_l_hold_nxt = w_resp_data;
                end else begin
                    w_m_hold_nxt = w_resp_data;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_win_l     <= 1'b0;
            r_we        <= 1'b0;
            r_oor       <= 1'b0;
            r_m_gnt     <= 1'b0;
            r_l_gnt     <= 1'b0;
            r_m_rvalid  <= 1'b0;
            r_l_rvalid  <= 1'b0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_busy      <= 1'b0;
            r_addr_err  <= 1'b0;
            r_m_hold    <= '0;
            r_l_hold    <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_win_l     <= w_win_l_nxt;
            r_we        <= w_we_nxt;
            r_oor       <= w_oor_nxt;
            r_m_gnt     <= w_m_gnt_nxt;
            r_l_gnt     <= w_l_gnt_nxt;
            r_m_rvalid  <= w_m_rvalid_nxt;
            r_l_rvalid  <= w_l_rvalid_nxt;
            r_mem_en    <= w_mem_en_nxt;
            r_mem_we    <= w_mem_we_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            r_busy      <= w_busy_nxt;
            r_addr_err  <= w_addr_err_nxt;
            r_m_hold    <= w_m_hold_nxt;
            r_l_hold    <= w_l_hold_nxt;
        end
    end

`ifdef DMEM_RR_EN
    // Round-robin pointer, favours m out of reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prio_l <= 1'b0;
        end else begin
            r_prio_l <= w_prio_l_nxt;
        end
    end
`endif

    assign m_gnt     = r_m_gnt;
    assign l_gnt     = r_l_gnt;
    assign m_rvalid  = r_m_rvalid;
    assign l_rvalid  = r_l_rvalid;
    assign mem_en    = r_mem_en;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign busy      = r_busy;
    assign addr_err  = r_addr_err;

    // Memory data only exists in the RESP cycle, so it is passed straight
    // through while rvalid is high and held in a register afterwards.
    assign m_rdata = r_m_rvalid ? w_resp_data : r_m_hold;
    assign l_rdata = r_l_rvalid ? w_resp_data : r_l_hold;

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have ports: clk  in  1  system clock, all state updates on rising edge.
REQ-002 SHALL have ports: rst_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports: m_req/m_we  in  1/1  memory-stage request, write enable.
REQ-004 SHALL have ports: m_addr/m_wdata  in  64/64  memory-stage byte-agnostic word index, write data.
REQ-005 SHALL have ports: m_gnt/m_rvalid  out  1/1  memory-stage grant pulse, response pulse; m_rdata  out  64  read data.
REQ-006 SHALL have ports: l_req/l_we/l_addr/l_wdata  in  1/1/64/64  loader-port request set, same meaning as m_*.
REQ-007 SHALL have ports: l_gnt/l_rvalid  out  1/1; l_rdata  out  64  loader-port responses.
REQ-008 SHALL have ports: mem_en/mem_we  out  1/1  single-port memory strobe, write enable; mem_addr  out  10  word index (1024 words).
REQ-009 SHALL have ports: mem_wdata  out  64; mem_rdata  in  64, valid the cycle after mem_en.
REQ-010 SHALL have ports: busy  out  1  FSM not IDLE; addr_err  out  1  out-of-range pulse.

Function
REQ-011 SHALL implement FSM IDLE -> ACCESS -> RESP -> IDLE, one transaction in flight.
REQ-012 SHALL, in IDLE, on any req sampled high, select a winner, latch its we/addr/wdata, enter ACCESS.
REQ-013 SHALL assert winner's gnt and mem_en for exactly the ACCESS cycle; loser sees no gnt.
REQ-014 SHALL drive mem_addr=latched addr[9:0], mem_we=latched we, mem_wdata=latched wdata during ACCESS; mem_en/mem_we=0 otherwise.
REQ-015 SHALL, in RESP, pulse winner's rvalid one cycle; rdata=mem_rdata for reads, 0 for writes; rdata holds until next rvalid.
REQ-016 SHALL give fixed latency: req sampled edge N -> gnt cycle N+1 -> rvalid cycle N+2; next acceptance earliest edge N+3.
REQ-017 SHALL require requesters to hold req and payload stable until gnt; req dropped before acceptance is ignored.
REQ-018 SHALL treat addr[63:10]!=0 as out of range: no mem_en/mem_we in ACCESS, gnt still issued, RESP pulses rvalid with rdata=0 and addr_err=1.
REQ-019 SHALL ignore requests arriving in ACCESS/RESP until return to IDLE.
REQ-020 SHALL never assert m_gnt and l_gnt, or m_rvalid and l_rvalid, in the same cycle.

Reset
REQ-021 SHALL on rst_n low immediately force IDLE, all outputs 0, rdata 0, priority pointer favouring m.
REQ-022 SHALL abandon a transaction cut by reset mid-ACCESS/RESP: no rvalid issued after release.
REQ-023 SHALL accept a new request on the first rising edge after rst_n deasserts.

Configuration
REQ-024 SHALL use macro DMEM_RR_EN: defined -> round-robin, simultaneous requests go to port not granted last; pointer updates on every grant.
REQ-025 SHALL without DMEM_RR_EN use fixed priority, m always wins simultaneous requests; no pointer state.

Verification
REQ-026 SHALL check read: preload word 4=0x2, m_req read addr 4 -> m_gnt cycle N+1 with mem_en, mem_addr=4; m_rvalid N+2, m_rdata=0x2.
REQ-027 SHALL check write: l_req write addr 10 data 0xDEAD -> ACCESS mem_we=1, mem_addr=10, mem_wdata=0xDEAD; l_rvalid with l_rdata=0; m read addr 10 returns 0xDEAD.
REQ-028 SHALL check contention: m_req and l_req held together for 4 transactions -> DMEM_RR_EN: m,l,m,l; without: m,m,m,m.
REQ-029 SHALL check range: m read addr 0x400 -> mem_en stays 0, m_rvalid=1, addr_err=1, m_rdata=0.
REQ-030 SHALL check reset: rst_n low during ACCESS -> outputs 0 same cycle, no rvalid after release, next req served with normal latency.
REQ-031 SHALL check back-to-back: m_req held continuously -> grants every 3 cycles, busy low exactly one cycle between.
